// File: rtl/cfu_wb_arbiter.sv
// Round-robin arbiter sharing the CFU Wishbone RAM master port between
// NUM_REQ requesters. One classic cycle in flight at a time; a per-transaction
// watchdog aborts a cycle that never sees ack/err.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational from req_valid
// BUS   | cyc/stb asserted with latched payload, waiting for ack/err/timeout
// RESP  | one-cycle completion pulse to the granted requester
module cfu_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*30-1:0] req_adr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  input  logic [NUM_REQ*4-1:0]  req_sel,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [29:0]           cfu_ram_adr,
  output logic [31:0]           cfu_ram_dat_mosi,
  output logic [3:0]            cfu_ram_sel,
  output logic                  cfu_ram_cyc,
  output logic                  cfu_ram_stb,
  output logic                  cfu_ram_we,
  output logic [2:0]            cfu_ram_cti,
  output logic [1:0]            cfu_ram_bte,
  input  logic [31:0]           cfu_ram_dat_miso,
  input  logic                  cfu_ram_ack,
  input  logic                  cfu_ram_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, grant, pick, rr_next;
  logic [GW:0]     slot;
  logic            found;
  logic            we_pick;
  logic [29:0]     adr_pick;
  logic [31:0]     wdata_pick;
  logic [3:0]      sel_pick;
  logic            we_q;
  logic [29:0]     adr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      sel_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            timeout_hit;

  // Round-robin search: scan downwards so the lowest offset from rr_ptr wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    slot  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      slot = {1'b0, rr_ptr} + (GW+1)'(i);
      if (slot >= (GW+1)'(NUM_REQ)) slot = slot - (GW+1)'(NUM_REQ);
      if (req_valid[slot[GW-1:0]]) begin
        found = 1'b1;
        pick  = slot[GW-1:0];
      end
    end
  end

  // Payload of the requester that would be granted this cycle.
  always_comb begin
    we_pick    = 1'b0;
    adr_pick   = '0;
    wdata_pick = '0;
    sel_pick   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == GW'(i)) begin
        we_pick    = req_we[i];
        adr_pick   = req_adr[30*i +: 30];
        wdata_pick = req_wdata[32*i +: 32];
        sel_pick   = req_sel[4*i +: 4];
      end
    end
  end

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign rr_next     = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake pulses.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = BUS;
          req_ready[pick] = 1'b1;
        end
      end
      BUS: begin
        if (cfu_ram_err || cfu_ram_ack || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        state_nxt        = IDLE;
        rsp_valid[grant] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction payload, watchdog counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      grant   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= pick;
            we_q    <= we_pick;
            adr_q   <= adr_pick;
            wdata_q <= wdata_pick;
            sel_q   <= sel_pick;
            cnt     <= '0;
          end
        end
        BUS: begin
          cnt <= cnt + CNT_W'(1);
          if (cfu_ram_err) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else if (cfu_ram_ack) begin
            rdata_q <= we_q ? 32'd0 : cfu_ram_dat_miso;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RESP: rr_ptr <= rr_next;
        default: ;
      endcase
    end
  end

  assign cfu_ram_cyc      = (state == BUS);
  assign cfu_ram_stb      = (state == BUS);
  assign cfu_ram_we       = (state == BUS) && we_q;
  assign cfu_ram_adr      = adr_q;
  assign cfu_ram_dat_mosi = wdata_q;
  assign cfu_ram_sel      = sel_q;
  assign cfu_ram_cti      = 3'b000;
  assign cfu_ram_bte      = 2'b00;
  assign rsp_rdata        = rdata_q;
  assign rsp_err          = err_q;

endmodule

// File: tb/tb_cfu_wb_arbiter.sv
// Bench for cfu_wb_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cfu_wb_arbiter;

  localparam int NR   = 2;
  localparam int TOUT = 8;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid, req_we, req_ready, rsp_valid;
  logic [NR*30-1:0] req_adr;
  logic [NR*32-1:0] req_wdata;
  logic [NR*4-1:0] req_sel;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;
  logic [29:0]     cfu_ram_adr;
  logic [31:0]     cfu_ram_dat_mosi, cfu_ram_dat_miso;
  logic [3:0]      cfu_ram_sel;
  logic            cfu_ram_cyc, cfu_ram_stb, cfu_ram_we, cfu_ram_ack, cfu_ram_err;
  logic [2:0]      cfu_ram_cti;
  logic [1:0]      cfu_ram_bte;

  cfu_wb_arbiter #(.NUM_REQ(NR), .TIMEOUT(TOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_sel(req_sel), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cfu_ram_adr(cfu_ram_adr), .cfu_ram_dat_mosi(cfu_ram_dat_mosi),
    .cfu_ram_sel(cfu_ram_sel), .cfu_ram_cyc(cfu_ram_cyc), .cfu_ram_stb(cfu_ram_stb),
    .cfu_ram_we(cfu_ram_we), .cfu_ram_cti(cfu_ram_cti), .cfu_ram_bte(cfu_ram_bte),
    .cfu_ram_dat_miso(cfu_ram_dat_miso), .cfu_ram_ack(cfu_ram_ack),
    .cfu_ram_err(cfu_ram_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- slave model ----------------
  int          ack_delay = 3;
  bit          err_mode  = 0;
  bit          stray     = 0;
  logic [31:0] slave_data = 32'd0;
  int          bus_cnt   = 0;

  // Slave acks on the ack_delay-th cycle of cyc (0 = never); optional err with it.
  always @(posedge clk) begin
    #1;
    if (cfu_ram_cyc) bus_cnt++;
    else bus_cnt = 0;
    cfu_ram_ack = stray || (cfu_ram_cyc && ack_delay != 0 && bus_cnt == ack_delay);
    cfu_ram_err = cfu_ram_cyc && err_mode && ack_delay != 0 && bus_cnt == ack_delay;
    cfu_ram_dat_miso = slave_data;
  end

  // ---------------- monitor logs ----------------
  typedef struct { logic [1:0] v; logic [31:0] d; logic e; int len; } rsp_t;
  rsp_t rsp_q[$];
  int   grant_q[$];
  int   cyc_run = 0, last_len = 0, txn_count = 0, both_cnt = 0;

  // ---------------- behavioural model ----------------
  typedef struct { int g; logic we; logic [29:0] adr; logic [31:0] wd; logic [3:0] sel; } txn_t;
  txn_t        cur;
  bit          busy = 0, resp = 0, model_on = 0;
  int          rr = 0, ncyc = 0, m_pick;
  logic [31:0] m_rdata = 32'd0;
  logic        m_err = 1'b0;
  logic [NR-1:0] exp_ready, exp_rsp;

  // Per-cycle: log DUT activity, compare against model, then advance model.
  always @(negedge clk) begin
    if (cfu_ram_cyc) begin
      if (cyc_run == 0) txn_count++;
      cyc_run++;
    end else if (cyc_run != 0) begin
      last_len = cyc_run;
      cyc_run  = 0;
    end
    if (|rsp_valid) rsp_q.push_back('{rsp_valid, rsp_rdata, rsp_err, last_len});
    for (int i = 0; i < NR; i++) if (req_ready[i]) grant_q.push_back(i);
    if (&rsp_valid) both_cnt++;

    m_pick = -1;
    if (!busy && !resp)
      for (int k = 0; k < NR; k++)
        if (m_pick < 0 && req_valid[(rr + k) % NR]) m_pick = (rr + k) % NR;
    exp_ready = '0;
    if (m_pick >= 0) exp_ready[m_pick] = 1'b1;
    exp_rsp = '0;
    if (resp) exp_rsp[cur.g] = 1'b1;

    if (model_on) begin
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
      chk("cyc", 64'(cfu_ram_cyc), 64'(busy));
      chk("stb", 64'(cfu_ram_stb), 64'(busy));
      chk("cti_bte", 64'({cfu_ram_cti, cfu_ram_bte}), 64'd0);
      if (busy) begin
        chk("bus_we", 64'(cfu_ram_we), 64'(cur.we));
        chk("bus_adr", 64'(cfu_ram_adr), 64'(cur.adr));
        chk("bus_dat", 64'(cfu_ram_dat_mosi), 64'(cur.wd));
        chk("bus_sel", 64'(cfu_ram_sel), 64'(cur.sel));
      end
      if (resp) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
      end
    end

    if (reset) begin
      busy = 0; resp = 0; rr = 0; model_on = 1;
    end else if (resp) begin
      resp = 0;
      rr   = (cur.g + 1) % NR;
    end else if (busy) begin
      ncyc++;
      if (cfu_ram_err) begin
        m_rdata = 0; m_err = 1; busy = 0; resp = 1;
      end else if (cfu_ram_ack) begin
        m_rdata = cur.we ? 32'd0 : cfu_ram_dat_miso; m_err = 0; busy = 0; resp = 1;
      end else if (ncyc == TOUT) begin
        m_rdata = 0; m_err = 1; busy = 0; resp = 1;
      end
    end else if (m_pick >= 0) begin
      cur.g   = m_pick;
      cur.we  = req_we[m_pick];
      cur.adr = req_adr[30*m_pick +: 30];
      cur.wd  = req_wdata[32*m_pick +: 32];
      cur.sel = req_sel[4*m_pick +: 4];
      busy = 1;
      ncyc = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_req(input int i, input int n, input logic we, input logic [29:0] adr,
                         input logic [31:0] wd, input logic [3:0] sel);
    bit got;
    @(posedge clk); #1;
    for (int t = 0; t < n; t++) begin
      req_valid[i] = 1'b1;
      req_we[i] = we;
      req_adr[30*i +: 30] = adr + 30'(t);
      req_wdata[32*i +: 32] = wd + 32'(t);
      req_sel[4*i +: 4] = sel;
      got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        got = req_ready[i];
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL accept_timeout req=%0d actual=no_ready expected=ready", i);
      end
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsps(input int n);
    for (int c = 0; c < 200 && rsp_q.size() < n; c++) @(posedge clk);
    if (rsp_q.size() < n) begin
      checks++; errors++;
      $display("FAIL rsp_timeout actual=%0d expected=%0d", rsp_q.size(), n);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc();
    bit seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      seen = cfu_ram_cyc;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL cyc_timeout actual=0 expected=1");
    end
  endtask

  task automatic expect_rsp(input string nm, input logic [1:0] v, input logic [31:0] d,
                            input logic e, input int len);
    rsp_t r;
    if (rsp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_missing actual=none expected=response", nm);
    end else begin
      r = rsp_q.pop_front();
      chk({nm, "_valid"}, 64'(r.v), 64'(v));
      chk({nm, "_rdata"}, 64'(r.d), 64'(d));
      chk({nm, "_err"}, 64'(r.e), 64'(e));
      chk({nm, "_cyclen"}, 64'(r.len), 64'(len));
    end
  endtask

  task automatic expect_grant(input string nm, input int g);
    if (grant_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_missing actual=none expected=%0d", nm, g);
    end else chk(nm, 64'(grant_q.pop_front()), 64'(g));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  int base;

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; req_valid = '0; req_we = '0; req_adr = '0; req_wdata = '0; req_sel = '0;
    cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0; cfu_ram_dat_miso = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_cyc_stb_we", 64'({cfu_ram_cyc, cfu_ram_stb, cfu_ram_we}), 64'd0);
    chk("rst_payload", 64'({cfu_ram_adr, cfu_ram_sel}), 64'd0);
    rsp_q.delete(); grant_q.delete();

    // single read, ack on 3rd cyc cycle
    ack_delay = 3; slave_data = 32'hDEADBEEF;
    run_req(0, 1, 1'b0, 30'h100, 32'h0, 4'hF);
    wait_rsps(1);
    expect_rsp("rd", 2'b01, 32'hDEADBEEF, 1'b0, 3);
    expect_grant("rd_grant", 0);

    // write from requester 1
    ack_delay = 2; slave_data = 32'hCAFEF00D;
    fork
      run_req(1, 1, 1'b1, 30'h2A, 32'h12345678, 4'b0011);
      begin
        wait_cyc();
        chk("wr_bus_we", 64'(cfu_ram_we), 64'd1);
        chk("wr_bus_dat", 64'(cfu_ram_dat_mosi), 64'h12345678);
        chk("wr_bus_sel", 64'(cfu_ram_sel), 64'b0011);
        chk("wr_bus_adr", 64'(cfu_ram_adr), 64'h2A);
        chk("wr_bus_cti", 64'(cfu_ram_cti), 64'd0);
      end
    join
    wait_rsps(1);
    expect_rsp("wr", 2'b10, 32'h0, 1'b0, 2);
    expect_grant("wr_grant", 1);

    // contention from reset: order 0,1,0,1
    pulse_reset();
    rsp_q.delete(); grant_q.delete(); both_cnt = 0;
    ack_delay = 1; slave_data = 32'h00001111;
    fork
      run_req(0, 2, 1'b0, 30'h10, 32'h0, 4'hF);
      run_req(1, 2, 1'b0, 30'h20, 32'h0, 4'hF);
    join
    wait_rsps(4);
    expect_grant("rr_g0", 0);
    expect_grant("rr_g1", 1);
    expect_grant("rr_g2", 0);
    expect_grant("rr_g3", 1);
    expect_rsp("rr_r0", 2'b01, 32'h00001111, 1'b0, 1);
    expect_rsp("rr_r1", 2'b10, 32'h00001111, 1'b0, 1);
    expect_rsp("rr_r2", 2'b01, 32'h00001111, 1'b0, 1);
    expect_rsp("rr_r3", 2'b10, 32'h00001111, 1'b0, 1);
    chk("rr_both_rsp", 64'(both_cnt), 64'd0);

    // err together with ack
    ack_delay = 2; err_mode = 1; slave_data = 32'h55AA55AA;
    run_req(0, 1, 1'b0, 30'h30, 32'h0, 4'hF);
    wait_rsps(1);
    expect_rsp("erack", 2'b01, 32'h0, 1'b1, 2);
    err_mode = 0;

    // timeout with no ack
    ack_delay = 0;
    run_req(1, 1, 1'b0, 30'h40, 32'h0, 4'hF);
    wait_rsps(1);
    expect_rsp("tmo", 2'b10, 32'h0, 1'b1, TOUT);

    // stray ack while idle does nothing
    base = txn_count;
    stray = 1;
    repeat (3) @(posedge clk);
    #1 stray = 0;
    repeat (2) @(posedge clk);
    chk("stray_txn", 64'(txn_count - base), 64'd0);
    chk("stray_rsp", 64'(rsp_q.size()), 64'd0);

    // withdrawal by requester 1 while requester 0 is on the bus
    grant_q.delete();
    ack_delay = 4; slave_data = 32'h0BADF00D;
    base = txn_count;
    fork
      run_req(0, 1, 1'b0, 30'h50, 32'h0, 4'hF);
      begin
        wait_cyc();
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_adr[59:30] = 30'h77;
        repeat (2) @(posedge clk);
        #1 req_valid[1] = 1'b0;
      end
    join
    wait_rsps(1);
    repeat (6) @(posedge clk);
    expect_rsp("wd", 2'b01, 32'h0BADF00D, 1'b0, 4);
    chk("wd_txns", 64'(txn_count - base), 64'd1);
    chk("wd_no_rsp", 64'(rsp_q.size()), 64'd0);
    expect_grant("wd_grant", 0);
    chk("wd_no_grant", 64'(grant_q.size()), 64'd0);

    // reset on 2nd BUS cycle of a request from 0 (rr currently points at 1)
    ack_delay = 5; slave_data = 32'h13572468;
    fork
      run_req(0, 1, 1'b0, 30'h60, 32'h0, 4'hF);
      begin
        wait_cyc();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    @(negedge clk);
    chk("rstbus_cyc", 64'(cfu_ram_cyc), 64'd0);
    repeat (6) @(posedge clk);
    chk("rstbus_no_rsp", 64'(rsp_q.size()), 64'd0);
    grant_q.delete();
    ack_delay = 2;
    fork
      run_req(0, 1, 1'b0, 30'h61, 32'h0, 4'hF);
      run_req(1, 1, 1'b0, 30'h62, 32'h0, 4'hF);
    join
    wait_rsps(2);
    expect_grant("rstbus_g0", 0);
    expect_grant("rstbus_g1", 1);
    expect_rsp("rstbus_r0", 2'b01, 32'h13572468, 1'b0, 2);
    expect_rsp("rstbus_r1", 2'b10, 32'h13572468, 1'b0, 2);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
